// File: rtl/axi_rt_budget_tracker.sv
// Per-region budget/period accounting for RT fragments: releases a fragment only while its
// region has budget left. Define AXI_RT_BUDGET_OVERRUN_EN to let the last fragment of a period overrun.
module axi_rt_budget_tracker #(
  parameter int unsigned NumRegions  = 2,
  parameter int unsigned BudgetWidth = 32,
  parameter int unsigned PeriodWidth = 32,
  parameter int unsigned BeatsWidth  = 9,
  parameter int unsigned RegIdxWidth = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              enable_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [RegIdxWidth-1:0]            req_region_i,
  input  logic [BeatsWidth-1:0]             req_beats_i,
  input  logic [NumRegions*BudgetWidth-1:0] budget_i,
  input  logic [NumRegions*PeriodWidth-1:0] period_i,
  output logic [NumRegions*BudgetWidth-1:0] budget_left_o,
  output logic [NumRegions*PeriodWidth-1:0] period_left_o,
  output logic [NumRegions-1:0]             exhausted_o
);

  logic [BudgetWidth-1:0] bl_q [NumRegions];
  logic [BudgetWidth-1:0] bl_d [NumRegions];
  logic [PeriodWidth-1:0] pl_q [NumRegions];
  logic [PeriodWidth-1:0] pl_d [NumRegions];
  logic [NumRegions-1:0]  exh_q;
  logic [NumRegions-1:0]  exh_d;

  logic [BudgetWidth-1:0] budget_cfg_s [NumRegions];
  logic [PeriodWidth-1:0] period_cfg_s [NumRegions];
  logic [NumRegions-1:0]  hit_s;
  logic [NumRegions-1:0]  unres_s;
  logic [NumRegions-1:0]  acc_s;
  logic [BudgetWidth-1:0] beats_ext_s;
  logic [BudgetWidth-1:0] sel_bl_s;
  logic                   in_range_s;
  logic                   sel_unres_s;
  logic                   fits_s;
  logic                   ready_s;

  function automatic logic [BudgetWidth-1:0] sat_sub(input logic [BudgetWidth-1:0] a,
                                                     input logic [BudgetWidth-1:0] b);
    return (a >= b) ? (a - b) : {BudgetWidth{1'b0}};
  endfunction

  // Strict mode guarantees budget >= beats at accept time, so a plain subtract suffices there.
  function automatic logic [BudgetWidth-1:0] charge(input logic [BudgetWidth-1:0] a,
                                                    input logic [BudgetWidth-1:0] b);
`ifdef AXI_RT_BUDGET_OVERRUN_EN
    return sat_sub(a, b);
`else
    return a - b;
`endif
  endfunction

  for (genvar r = 0; r < NumRegions; r++) begin : g_region
    assign budget_cfg_s[r] = budget_i[r*BudgetWidth +: BudgetWidth];
    assign period_cfg_s[r] = period_i[r*PeriodWidth +: PeriodWidth];
    assign budget_left_o[r*BudgetWidth +: BudgetWidth] = bl_q[r];
    assign period_left_o[r*PeriodWidth +: PeriodWidth] = pl_q[r];
    assign hit_s[r]   = ({1'b0, req_region_i} == (RegIdxWidth+1)'(r));
    assign unres_s[r] = (period_cfg_s[r] == {PeriodWidth{1'b0}});
    assign acc_s[r]   = req_valid_i & ready_s & hit_s[r];
  end

  assign beats_ext_s = BudgetWidth'(req_beats_i);
  assign in_range_s  = |hit_s;
  assign req_ready_o = ready_s;
  assign exhausted_o = exh_q;

  // Readiness is a function of the addressed region's live budget only, never of req_valid_i.
  always_comb begin
    sel_bl_s    = {BudgetWidth{1'b0}};
    sel_unres_s = 1'b0;
    for (int r = 0; r < NumRegions; r++) begin
      sel_bl_s    = sel_bl_s | (hit_s[r] ? bl_q[r] : {BudgetWidth{1'b0}});
      sel_unres_s = sel_unres_s | (hit_s[r] & unres_s[r]);
    end
`ifdef AXI_RT_BUDGET_OVERRUN_EN
    fits_s = (sel_bl_s != {BudgetWidth{1'b0}});
`else
    fits_s = (sel_bl_s >= beats_ext_s);
`endif
    ready_s = ~rst_i & (~enable_i | ~in_range_s | sel_unres_s | fits_s);
  end

  // Per-region next state: bypass/unrestricted shadow the config, otherwise count down and charge.
  always_comb begin
    for (int r = 0; r < NumRegions; r++) begin
      bl_d[r] = bl_q[r];
      pl_d[r] = pl_q[r];
      if (!enable_i || unres_s[r]) begin
        bl_d[r] = budget_cfg_s[r];
        pl_d[r] = period_cfg_s[r];
      end else if (pl_q[r] <= PeriodWidth'(1)) begin
        pl_d[r] = period_cfg_s[r];
        bl_d[r] = acc_s[r] ? sat_sub(budget_cfg_s[r], beats_ext_s) : budget_cfg_s[r];
      end else begin
        pl_d[r] = pl_q[r] - PeriodWidth'(1);
        bl_d[r] = acc_s[r] ? charge(bl_q[r], beats_ext_s) : bl_q[r];
      end
      exh_d[r] = (bl_d[r] == {BudgetWidth{1'b0}});
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NumRegions; r++) begin
        bl_q[r] <= {BudgetWidth{1'b0}};
        pl_q[r] <= {PeriodWidth{1'b0}};
      end
      exh_q <= {NumRegions{1'b0}};
    end else begin
      for (int r = 0; r < NumRegions; r++) begin
        bl_q[r] <= bl_d[r];
        pl_q[r] <= pl_d[r];
      end
      exh_q <= exh_d;
    end
  end

endmodule
